bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Multi-bit adder that computes `A + B + cin` one bit per clock, LSB first, using a single full-adder cell built from two `one_bit_half_adder` instances. It sits directly downstream of the half-adder primitive and consumes its `sum`/`cout` outputs every cycle. A carry flip-flop and operand shift registers replace a ripple chain. It presents a start/busy/done handshake to the surrounding datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 1.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new addition; sampled only in IDLE or DONE.
- `a_in`, input, WIDTH: operand A, captured on the accepting edge.
- `b_in`, input, WIDTH: operand B, captured on the accepting edge.
- `cin`, input, 1: carry-in, captured on the accepting edge.
- `busy`, output, 1: high while the adder is in SHIFT.
- `done`, output, 1: one-cycle pulse; `sum`/`cout` are valid from this cycle.
- `sum`, output, WIDTH: result register; holds its value until the next completion.
- `cout`, output, 1: final carry-out; holds its value until the next completion.

## Operation
- States are IDLE, SHIFT and DONE.
- Reset values: state IDLE; all of `busy`, `done`, `sum`, `cout`, operand shift registers, carry flop and bit counter are 0.
- **IDLE**, `start` = 1:
  - load `a_in` and `b_in` into the shift registers;
  - load the carry flop with `cin`;
  - clear the counter;
  - go to SHIFT.
- **SHIFT**, every edge:
  - half adder 1 adds `a_sr[0]` and `b_sr[0]`;
  - half adder 2 adds that `sum` to the carry flop;
  - the bit is `sum2`;
  - the carry flop takes `cout1 | cout2`;
  - the bit shifts into the MSB of the partial-sum register, while `a_sr` and `b_sr` shift right;
  - the counter increments.
- **SHIFT exit**: on the edge where counter = WIDTH-1:
  - copy the completed partial sum into `sum`;
  - copy the new carry into `cout`;
  - go to DONE.
- **DONE**:
  - `done` = 1 for exactly this cycle.
  - If `start` = 1, accept new operands exactly as in IDLE and go to SHIFT.
  - Otherwise go to IDLE.
- `start` during SHIFT is ignored; it is neither queued nor allowed to corrupt the operation in progress.
- Operands may change freely after the accepting edge.
- Width rule: the result equals `(A + B + cin) mod 2^WIDTH`, and `cout` is bit WIDTH of that sum.
- Counter width: `$clog2(WIDTH)`, minimum 1 bit.
- `rst` mid-operation: return to IDLE on that edge, with no `done` pulse and `sum`/`cout` cleared to 0.
- `rst` and `start` asserted together: `rst` wins.

## Timing
- Start is accepted at edge E0.
- `busy` is high from after E0 through E0+WIDTH, i.e. exactly WIDTH cycles.
- `done`, `sum` and `cout` update at edge E0+WIDTH.
- Latency is WIDTH cycles from the accepting edge to `done`.
- Back-to-back throughput: one addition per WIDTH+1 cycles when `start` is held high in DONE.
- Otherwise the minimum is WIDTH+2 cycles, because DONE passes through IDLE.
- `busy` and `done` are never high in the same cycle.
- `sum` never shows a partial result.
- WIDTH = 1 case: a single SHIFT cycle, then DONE.

## Structure
- Shared package `bit_serial_pkg` holds:
  - the state encodings IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - default `WIDTH`.
- One sub-module, `serial_full_adder_cell`: two `one_bit_half_adder` instances plus the OR for carry. It is purely combinational; the carry flop stays in the parent.
- FSM, shift registers and counter live in `bit_serial_adder`.

## Test plan
All scenarios use WIDTH = 8 unless stated.
- Reset, then 0x00 + 0x00, `cin` = 0 → `sum` = 0x00, `cout` = 0; `done` exactly 8 cycles after the accepting edge; `busy` high for 8 cycles.
- 0xFF + 0x01, `cin` = 0 → `sum` = 0x00, `cout` = 1. Then 0x3C + 0x42, `cin` = 0 → `sum` = 0x7E, `cout` = 0.
- 0xA5 + 0x5A, `cin` = 1 → `sum` = 0x00, `cout` = 1 (checks full carry ripple through the flop).
- Pulse `start` with new operands at cycle 3 of SHIFT → ignored; the result equals the first operation only.
- Assert `rst` at SHIFT cycle 4 → next cycle: IDLE, `busy` = 0, `sum` = 0, no `done` pulse.
- Hold `start` in DONE with 0x10 + 0x20 → SHIFT re-entered immediately; second `done` arrives 9 cycles after the first with `sum` = 0x30. Separate bench with WIDTH = 1: 1 + 1, `cin` = 1 → `sum` = 1, `cout` = 1.

Source files
------------

// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package bit_serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bit_serial_pkg

// File: rtl/one_bit_half_adder.sv
// Half-adder primitive: sum = a ^ b, cout = a & b (purely combinational).
// Ports: a, b - addend bits; sum - XOR result; cout - AND carry.
module one_bit_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule : one_bit_half_adder

// File: rtl/serial_full_adder_cell.sv
// Combinational full-adder cell built from two half adders plus a carry OR.
// Ports: a, b - operand bits; cin - carry from the parent's carry flop;
//        sum_c - result bit; cout_c - carry to be registered by the parent.
module serial_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    logic sum1_c;
    logic cout1_c;
    logic cout2_c;

    one_bit_half_adder u_ha1 (
        .a    (a),
        .b    (b),
        .sum  (sum1_c),
        .cout (cout1_c)
    );

    one_bit_half_adder u_ha2 (
        .a    (sum1_c),
        .b    (cin),
        .sum  (sum_c),
        .cout (cout2_c)
    );

    // Both half-adder carries can never be high together, so OR equals the true carry.
    assign cout_c = cout1_c | cout2_c;

endmodule : serial_full_adder_cell

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: computes a_in + b_in + cin one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); start - request, sampled in IDLE/DONE;
//        a_in, b_in, cin - operands captured on the accepting edge;
//        busy - high during SHIFT; done - one-cycle completion pulse;
//        sum, cout - registered result, held until the next completion.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_c;
    logic             carry_c;
    logic [WIDTH-1:0] result_c;

    serial_full_adder_cell u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cin    (carry),
        .sum_c  (bit_c),
        .cout_c (carry_c)
    );

    // Partial sum keeps only the WIDTH-1 bits already produced; the bit of the
    // current cycle joins them combinationally to form the shifted-in value.
    if (WIDTH == 1) begin : g_narrow
        assign result_c = bit_c;
    end else begin : g_wide
        logic [WIDTH-2:0] psum;

        assign result_c = {bit_c, psum};

        always_ff @(posedge clk) begin
            if (rst) begin
                psum <= '0;
            end else if (state == SHIFT) begin
                psum <= result_c[WIDTH-1:1];
            end
        end
    end

    // Control FSM, operand shift registers, carry flop and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= result_c;
                        cout  <= carry_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH = 8 and WIDTH = 1 instances).
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int passed = 0;
    int total  = 0;

    logic [7:0] last_sum;
    logic       last_cout;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a_in  (a1),
        .b_in  (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One WIDTH=8 addition from the accepting edge through the done cycle.
    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit inject);
        logic [8:0] exp;
        exp   = 9'(a) + 9'(b) + 9'(c);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        cin   = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
        for (int k = 1; k < 8; k++) begin
            if (inject && k == 3) begin
                start = 1'b1;
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
                cin   = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_shift", 32'(busy), 32'd1);
            chk("done_shift", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(exp[7:0]));
        chk("cout", 32'(cout), 32'(exp[8]));
        last_sum  = exp[7:0];
        last_cout = exp[8];
    endtask

    // One idle cycle after DONE: pulse ends and the result holds.
    task automatic idle_step8();
        @(posedge clk); #1;
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sum_held", 32'(sum), 32'(last_sum));
        chk("cout_held", 32'(cout), 32'(last_cout));
    endtask

    task automatic do_add1(input logic a, input logic b, input logic c);
        logic [1:0] exp;
        exp    = 2'(a) + 2'(b) + 2'(c);
        start1 = 1'b1;
        a1     = a;
        b1     = b;
        cin1   = c;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1     = ~a;
        b1     = ~b;
        cin1   = ~c;
        chk("w1_busy", 32'(busy1), 32'd1);
        chk("w1_done_early", 32'(done1), 32'd0);
        @(posedge clk); #1;
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_busy_done", 32'(busy1), 32'd0);
        chk("w1_sum", 32'(sum1), 32'(exp[0]));
        chk("w1_cout", 32'(cout1), 32'(exp[1]));
        @(posedge clk); #1;
        chk("w1_done_cleared", 32'(done1), 32'd0);
    endtask

    initial begin
        logic saw_done;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w1_busy", 32'(busy1), 32'd0);
        chk("rst_w1_sum", 32'(sum1), 32'd0);

        do_add8(8'h00, 8'h00, 1'b0, 1'b0);
        idle_step8();
        do_add8(8'hFF, 8'h01, 1'b0, 1'b0);
        idle_step8();
        do_add8(8'h3C, 8'h42, 1'b0, 1'b0);
        idle_step8();

        // Reset during SHIFT: no done pulse, result cleared.
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'h11;
        cin   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            saw_done = saw_done | done | busy;
        end
        chk("midrst_quiet", 32'(saw_done), 32'd0);

        // Reset and start together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);

        do_add8(8'hA5, 8'h5A, 1'b1, 1'b0);
        idle_step8();

        // Start pulse mid-SHIFT is ignored.
        do_add8(8'h81, 8'h7E, 1'b0, 1'b1);
        idle_step8();
        chk("inject_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: second start issued in the DONE cycle.
        do_add8(8'h55, 8'h66, 1'b1, 1'b0);
        do_add8(8'h10, 8'h20, 1'b0, 1'b0);
        idle_step8();

        for (int i = 0; i < 20; i++) begin
            do_add8(8'($urandom), 8'($urandom), 1'($urandom), (i % 5) == 2);
            if ((i % 2) == 0) idle_step8();
        end
        idle_step8();

        do_add1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            do_add1(1'(i >> 2), 1'(i >> 1), 1'(i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_bit_serial_adder
